// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multi-cycle multiply/divide for EX; define MULDIV_EARLY_OUT_EN to shortcut zero operands
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [9:0]       funct_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d, is_rem_q, is_rem_d;
  logic                 q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;
  logic [WIDTH-1:0]     result_d;

  logic [2:0]           f3;
  logic                 supported, accept, rs1_neg, rs2_neg;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH:0]       mul_sum, rem_sh;
  logic [WIDTH-1:0]     div_diff, quo, rem, final_res;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_next, div_next, iter_next;

  assign f3        = funct_i[2:0];
  assign supported = (funct_i[9:3] == 7'b0000001) & ((f3 == 3'b000) | f3[2]);
  assign accept    = start_i & ~flush_i;
  assign rs1_neg   = f3[2] & ~f3[0] & rs1_i[WIDTH-1];
  assign rs2_neg   = f3[2] & ~f3[0] & rs2_i[WIDTH-1];
  assign abs1      = rs1_neg ? -rs1_i : rs1_i;
  assign abs2      = rs2_neg ? -rs2_i : rs2_i;

  // Multiply: {partial, multiplier} shifts right, partial gets multiplicand when the low bit is set
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: {remainder, dividend} shifts left, quotient bits enter at the bottom
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = rem_sh >= {1'b0, opb_q};
  assign div_diff = rem_sh[WIDTH-1:0] - opb_q;
  assign div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign iter_next = is_div_q ? div_next : mul_next;
  assign quo       = iter_next[WIDTH-1:0];
  assign rem       = iter_next[2*WIDTH-1:WIDTH];

  // A zero divisor yields all-ones regardless of operand signs, so skip quotient negation
  always_comb begin
    final_res = quo;
    if (is_div_q) begin
      if (is_rem_q) final_res = r_neg_q ? -rem : rem;
      else          final_res = (q_neg_q & ~div0_q) ? -quo : quo;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div0_d   = div0_q;
    result_d = result_o;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!supported) begin
            result_d = '0;
            state_d  = DONE;
          end else begin
            cnt_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, (f3[2] ? abs1 : rs2_i)};
            opb_d    = f3[2] ? abs2 : rs1_i;
            is_div_d = f3[2];
            is_rem_d = f3[1];
            q_neg_d  = rs1_neg ^ rs2_neg;
            r_neg_d  = rs1_neg;
            div0_d   = (rs2_i == '0);
            state_d  = BUSY;
`ifdef MULDIV_EARLY_OUT_EN
            if ((rs1_i == '0) || (rs2_i == '0)) begin
              state_d = DONE;
              if (f3[2] && (rs2_i == '0)) result_d = f3[1] ? rs1_i : '1;
              else                         result_d = '0;
            end
`endif
          end
        end
      end
      BUSY: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      result_o <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      div0_q   <= div0_d;
      result_o <= result_d;
    end
  end

  assign stall_o = (state_q == BUSY) | ((state_q == IDLE) & accept);
  assign done_o  = (state_q == DONE) & ~flush_i;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [9:0]  funct;
  logic [31:0] rs1, rs2;
  logic        stall, done;
  logic [31:0] result;
  int          checks = 0;
  int          failures = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .funct_i(funct), .rs1_i(rs1), .rs2_i(rs2),
    .stall_o(stall), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int zero_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    return ((a == 0) || (b == 0)) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Issue one op from an IDLE cycle, hold start until done, then check latency and result
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   n;
    logic stall_ok;
    funct = {7'b0000001, f3};
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    #1;
    chk({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
    n        = 0;
    stall_ok = 1'b1;
    do begin
      tick();
      n++;
      if (!done && !stall) stall_ok = 1'b0;
    end while (!done && n < 100);
    start = 1'b0;
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    chk({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int n2;
    logic seen_done;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; rs1 = '0; rs2 = '0;
    repeat (3) tick();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    repeat (6) tick();

    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, 33);
    run_op("mul_neg3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_by0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, zero_lat(32'd100, 32'd0));
    run_op("remu_by0", 3'b111, 32'd100, 32'd0, 32'd100, zero_lat(32'd100, 32'd0));
    run_op("div_m7_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, zero_lat(32'd1, 32'd0));
    run_op("rem_m7_by0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, zero_lat(32'd1, 32'd0));
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("div_0_by5", 3'b100, 32'd0, 32'd5, 32'd0, zero_lat(32'd0, 32'd5));
    run_op("unsup_001", 3'b001, 32'd9, 32'd9, 32'd0, 1);
    run_op("mul_by0", 3'b000, 32'd9, 32'd0, 32'd0, zero_lat(32'd9, 32'd0));

    // Back-to-back: start stays high through DONE with the next operands
    funct = {7'b0000001, 3'b000}; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!done && n < 100);
    chk("b2b_first_latency", n, 33);
    chk("b2b_first_result", result, 32'd12);
    rs1 = 32'd5; rs2 = 32'd5;
    n2 = 0;
    do begin tick(); n2++; end while (!done && n2 < 100);
    start = 1'b0;
    chk("b2b_spacing", n2, 34);
    chk("b2b_second_result", result, 32'd25);
    tick();

    // Flush five cycles into BUSY: no done, result keeps 25
    funct = {7'b0000001, 3'b000}; rs1 = 32'd11; rs2 = 32'd11; start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);
    chk("flush_no_done", {31'd0, done}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("flush_no_late_done", {31'd0, seen_done}, 32'd0);
    chk("flush_result_kept", result, 32'd25);

    // Asynchronous reset in the middle of BUSY
    funct = {7'b0000001, 3'b101}; rs1 = 32'd50; rs2 = 32'd3; start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("rst_no_done", {31'd0, seen_done}, 32'd0);

    run_op("post_rst_divu", 3'b101, 32'd50, 32'd3, 32'd16, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched funct field and both register operands.
- Holds the pipeline through stall_o while iterating.
- Presents a registered result to the EX/MEM path on done_o.
- One-bit-per-cycle shift-add multiply and restoring divide, sharing one 2*WIDTH-bit accumulator.

Parameters:
WIDTH, 32, operand/result width; the counter width is clog2(WIDTH).

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  EX holds an M-extension instruction (funct7 = 0000001) this cycle
flush_i  input  1  abort the current operation (branch/hazard flush of EX)
funct_i  input  10  {funct7, funct3} as latched by the ID/EX register
rs1_i  input  WIDTH  RS1 data (dividend / multiplicand)
rs2_i  input  WIDTH  RS2 data (divisor / multiplier)
stall_o  output  1  freeze PC, IF/ID and ID/EX
done_o  output  1  one-cycle pulse: result_o valid this cycle
result_o  output  WIDTH  registered result

Behaviour:
- Supported funct3 values: 000 MUL (low WIDTH bits), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- funct3 values 001, 010 and 011 are "unsupported": result 0, 1-cycle path.
- States: IDLE, BUSY, DONE. Reset values: state IDLE, counter 0, done_o 0, result_o 0, accumulator 0.
- IDLE:
  - start_i=1 and not flush_i in cycle C: capture operands and op.
  - Signed DIV/REM: store the absolute values, plus the quotient sign (rs1[31]^rs2[31]) and the remainder sign (rs1[31]).
  - Go to BUSY with counter=0.
  - Unsupported op: go directly to DONE.
- BUSY: one iteration per cycle, cycles C+1 to C+WIDTH. Leave when counter==WIDTH-1, then go to DONE.
- DONE (cycle C+WIDTH+1):
  - done_o=1; result_o updated on the edge entering DONE; sign correction already applied.
  - Next state IDLE.
  - start_i is ignored in DONE (it is the same instruction still sitting in ID/EX).
- Latency: done_o asserts exactly WIDTH+1 cycles after acceptance (33 for WIDTH=32). Unsupported ops assert done_o after 1 cycle.
- stall_o is combinational: (state==BUSY) | (state==IDLE & start_i & ~flush_i). It is 0 in DONE, so the pipeline advances and EX/MEM captures result_o.
- Back-to-back: a new start_i in the IDLE cycle after DONE is accepted normally. There is no dead cycle beyond the IDLE check.
- Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = rs1 unchanged; full latency still applies.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- MUL: result is the low WIDTH bits of the product, identical for any operand sign interpretation.
- Flush:
  - flush_i in BUSY or DONE forces IDLE on the next edge.
  - No done_o is generated; result_o keeps its previous value.
  - flush_i wins over start_i in IDLE.
- Reset mid-operation: immediate return to IDLE, all outputs at reset values, no done_o.
- result_o holds its value until the next DONE. It is not cleared on accept.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: if in IDLE rs1_i==0 or rs2_i==0 at acceptance, skip BUSY and enter DONE next cycle (latency 1).
  - MUL result is 0.
  - DIV/DIVU with rs2=0: result 0xFFFFFFFF.
  - REM/REMU with rs2=0: result rs1.
  - rs1=0 division: result 0.
- Undefined: these cases take the full WIDTH+1 latency with identical results.

Test Plan:
- MUL rs1=7, rs2=6 accepted at cycle 10 -> stall_o=1 for cycles 10-42, done_o=1 at cycle 43, result_o=42, stall_o=0 at 43.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIVU rs1=100, rs2=0 -> 0xFFFFFFFF; REMU rs1=100, rs2=0 -> 100; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Start MUL, assert flush_i at cycle C+5 -> IDLE at C+6, no done_o, result_o unchanged; rst_i pulse mid-BUSY -> stall_o=0, result_o=0 immediately.
- Two consecutive MULs (3*4 then 5*5) -> done_o pulses 34 cycles apart, results 12 then 25; funct3=001 -> done_o after 1 cycle, result 0.
- MULDIV_EARLY_OUT_EN defined, MUL rs2=0 -> done_o one cycle after accept, result 0; undefined -> done_o after 33 cycles, result 0.
